audio_gain_ctrl: RTL and testbench



---
 rtl/audio_gain_ctrl.sv | 128 ++++++++++++
 tb/tb_audio_gain_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_gain_ctrl.sv
// Volume/mute controller: level register, click-free gain ramp toward a
// level-derived target, and an N-channel fixed-point sample scaler.
module audio_gain_ctrl #(
  parameter int NCH       = 2,
  parameter int SAMPLE_W  = 16,
  parameter int LEVEL_W   = 3,
  parameter int MIN_LEVEL = 1,
  parameter int MAX_LEVEL = 5,
  parameter int DEF_LEVEL = 3,
  parameter int GAIN_W    = 16,
  parameter int GAIN_STEP = 12000,
  parameter int RAMP_DIV  = 1000,
  parameter int RAMP_INC  = 600
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vol_up,
  input  logic                    vol_down,
  input  logic                    mute,
  input  logic                    in_valid,
  input  logic [NCH*SAMPLE_W-1:0] in_data,
  output logic [LEVEL_W-1:0]      level,
  output logic [GAIN_W-1:0]       gain,
  output logic                    ramping,
  output logic [1:0]              state,
  output logic                    out_valid,
  output logic [NCH*SAMPLE_W-1:0] out_data
);

  // state        | meaning
  // ST_IDLE      | gain equals target
  // ST_RAMP_UP   | gain below target, stepping up on ticks
  // ST_RAMP_DOWN | gain above target, stepping down on ticks
  // ST_MUTED     | mute active and gain fully at zero
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_RAMP_DOWN = 2'd2,
    ST_MUTED     = 2'd3
  } state_t;

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [GAIN_W-1:0]  STEP     = GAIN_W'(GAIN_STEP);
  localparam logic [GAIN_W-1:0]  INC      = GAIN_W'(RAMP_INC);
  localparam logic [LEVEL_W-1:0] MIN_L    = LEVEL_W'(MIN_LEVEL);
  localparam logic [LEVEL_W-1:0] MAX_L    = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] DEF_L    = LEVEL_W'(DEF_LEVEL);

  logic [LEVEL_W-1:0]      level_q, level_d;
  logic [GAIN_W-1:0]       gain_q, gain_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  state_t                  state_q, state_d;
  logic                    out_valid_q, out_valid_d;
  logic [NCH*SAMPLE_W-1:0] out_data_q, out_data_d;
  logic [GAIN_W-1:0]       target;
  logic                    tick;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q     <= DEF_L;
      gain_q      <= '0;
      cnt_q       <= '0;
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      level_q     <= level_d;
      gain_q      <= gain_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    level_d = level_q;
    if (!mute) begin
      if (vol_up && !vol_down && (level_q < MAX_L))
        level_d = level_q + LEVEL_W'(1);
      else if (vol_down && !vol_up && (level_q > MIN_L))
        level_d = level_q - LEVEL_W'(1);
    end

    target = mute ? '0
                  : GAIN_W'({{GAIN_W{1'b0}}, level_q} * {{LEVEL_W{1'b0}}, STEP});

    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

    // Distance is compared against the step before adding, so gain never wraps or overshoots.
    gain_d = gain_q;
    if (tick) begin
      if (gain_q < target)
        gain_d = ((target - gain_q) > INC) ? gain_q + INC : target;
      else if (gain_q > target)
        gain_d = ((gain_q - target) > INC) ? gain_q - INC : target;
    end

    if (mute && (gain_d == '0))
      state_d = ST_MUTED;
    else if (gain_d == target)
      state_d = ST_IDLE;
    else if (gain_d < target)
      state_d = ST_RAMP_UP;
    else
      state_d = ST_RAMP_DOWN;

    out_valid_d = in_valid;
    out_data_d  = out_data_q;
    if (in_valid) begin
      for (int c = 0; c < NCH; c++) begin
        out_data_d[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(
          ($signed({{(GAIN_W+1){in_data[c*SAMPLE_W+SAMPLE_W-1]}}, in_data[c*SAMPLE_W +: SAMPLE_W]}) *
           $signed({{SAMPLE_W{1'b0}}, 1'b0, gain_q})) >>> GAIN_W);
      end
    end
  end

  assign level     = level_q;
  assign gain      = gain_q;
  assign state     = state_q;
  assign ramping   = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_audio_gain_ctrl.sv
// Bench for audio_gain_ctrl: directed control sequences with a sample
// scoreboard (expected samples queued at issue, popped by a monitor).
module tb_audio_gain_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vol_up = 1'b0;
  logic        vol_down = 1'b0;
  logic        mute = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  level;
  logic [15:0] gain;
  logic        ramping;
  logic [1:0]  state;
  logic        out_valid;
  logic [31:0] out_data;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  logic [31:0] exp_q[$];

  audio_gain_ctrl #(
    .RAMP_DIV (2),
    .RAMP_INC (6000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vol_up    (vol_up),
    .vol_down  (vol_down),
    .mute      (mute),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .level     (level),
    .gain      (gain),
    .ramping   (ramping),
    .state     (state),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got ch0=%0d ch1=%0d with nothing pending",
                 $signed(out_data[15:0]), $signed(out_data[31:16]));
      end else begin
        e = exp_q.pop_front();
        pops++;
        if (out_data !== e) begin
          errors++;
          $display("FAIL sample: got ch0=%0d ch1=%0d expected ch0=%0d ch1=%0d",
                   $signed(out_data[15:0]), $signed(out_data[31:16]),
                   $signed(e[15:0]), $signed(e[31:16]));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic up, input logic down);
    vol_up = up;
    vol_down = down;
    @(negedge clk);
    vol_up = 1'b0;
    vol_down = 1'b0;
  endtask

  // Leaves in_valid high so callers can stream back-to-back.
  task automatic send(input int ch0, input int ch1, input int e0, input int e1);
    logic [31:0] d;
    logic [31:0] e;
    d = {ch1[15:0], ch0[15:0]};
    e = {e1[15:0], e0[15:0]};
    in_valid = 1'b1;
    in_data = d;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic wait_gain(input int tgt, input int budget, input string name);
    int n;
    n = 0;
    while (int'(gain) != tgt && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(gain), tgt);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_level"}, int'(level), 3);
    chk({tag, "_gain"}, int'(gain), 0);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_ramping"}, int'(ramping), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_data"}, int'(out_data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "bench timeout");
  end

  initial begin
    int pops_before;

    // Reset and soft start
    cyc(3);
    chk_reset_values("reset");
    rst_n = 1'b1;
    cyc(1);
    chk("soft_start_state", int'(state), 1);
    chk("soft_start_ramping", int'(ramping), 1);
    chk("soft_start_gain", int'(gain), 0);
    cyc(1);
    chk("first_step_gain", int'(gain), 6000);
    cyc(10);
    chk("settle_gain", int'(gain), 36000);
    chk("settle_state", int'(state), 0);
    chk("settle_ramping", int'(ramping), 0);

    // Level limits
    repeat (4) pulse(1'b1, 1'b0);
    chk("level_max", int'(level), 5);
    wait_gain(60000, 40, "gain_max");
    chk("gain_max_state", int'(state), 0);
    repeat (6) pulse(1'b0, 1'b1);
    chk("level_min", int'(level), 1);
    wait_gain(12000, 60, "gain_min");
    chk("gain_min_state", int'(state), 0);
    pulse(1'b1, 1'b1);
    chk("both_pressed", int'(level), 1);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk("level_back_3", int'(level), 3);
    wait_gain(36000, 40, "gain_back_36000");

    // Mute
    mute = 1'b1;
    cyc(1);
    chk("mute_ramp_down", int'(state), 2);
    wait_gain(0, 20, "mute_gain_zero");
    chk("muted_state", int'(state), 3);
    chk("muted_ramping", int'(ramping), 0);
    repeat (2) pulse(1'b1, 1'b0);
    chk("muted_level_hold", int'(level), 3);
    send(1234, -777, 0, 0);
    in_valid = 1'b0;
    cyc(1);
    mute = 1'b0;
    cyc(1);
    chk("unmute_state", int'(state), 1);
    wait_gain(36000, 20, "unmute_gain");
    chk("unmute_idle", int'(state), 0);

    // Scaling at gain 36000
    send(16384, -16384, 9000, -9000);
    in_valid = 1'b0;
    cyc(2);

    // Mid-ramp target reversal
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    wait_gain(18000, 20, "ramp_to_18000");
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk("reversal_level", int'(level), 1);
    chk("reversal_gain_a", int'(gain), 24000);
    cyc(2);
    chk("reversal_gain_b", int'(gain), 18000);
    chk("reversal_state_down", int'(state), 2);
    cyc(2);
    chk("reversal_gain_c", int'(gain), 12000);
    chk("reversal_state_idle", int'(state), 0);
    cyc(4);
    chk("reversal_no_overshoot", int'(gain), 12000);

    // Reset mid-ramp with a sample in flight
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    wait_gain(24000, 20, "ramp_to_24000");
    chk("midramp_state", int'(state), 1);
    send(16384, 0, 6000, 0);
    in_data = 32'h1234_4321;
    rst_n = 1'b0;
    cyc(1);
    chk_reset_values("midramp_reset");
    rst_n = 1'b1;
    in_valid = 1'b0;

    // Streaming
    wait_gain(36000, 30, "stream_gain");
    chk("stream_state", int'(state), 0);
    pops_before = pops;
    for (int i = 0; i < 8; i++)
      send(i * 4096, -i * 4096, i * 2250, -i * 2250);
    in_valid = 1'b0;
    cyc(2);
    chk("stream_count", pops - pops_before, 8);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
